// File: rtl/apb_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_xfer_ctrl_if
// Brief    : AHB-Lite slave-port and APB master-port bundle for apb_xfer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_xfer_ctrl_if #(
    parameter int NUM_SLAVES = 4
);
    logic                  Hsel;
    logic [1:0]            Htrans;
    logic [31:0]           Haddr;
    logic                  Hwrite;
    logic [31:0]           Hwdata;
    logic                  Hready_in;
    logic                  Hreadyout;
    logic [1:0]            Hresp;
    logic [31:0]           Hrdata;
    logic [NUM_SLAVES-1:0] Psel;
    logic                  Penable;
    logic                  Pwrite;
    logic [31:0]           Paddr;
    logic [31:0]           Pwdata;
    logic [31:0]           Prdata;
    logic                  Pready;
    logic                  Pslverr;

    // master: the transfer controller (drives the APB side, answers AHB)
    modport master (
        input  Hsel, Htrans, Haddr, Hwrite, Hwdata, Hready_in,
        output Hreadyout, Hresp, Hrdata,
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    // slave: the surrounding AHB interconnect and APB slave bank
    modport slave (
        output Hsel, Htrans, Haddr, Hwrite, Hwdata, Hready_in,
        input  Hreadyout, Hresp, Hrdata,
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_xfer_ctrl
// Brief    : AHB-Lite to APB transfer sequencer with wait-state/error handling.
// Revision : 1.0 - initial release
// ============================================================================
module apb_xfer_ctrl #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12
) (
    input  wire logic         Hclk,
    input  wire logic         Hresetn,
    apb_xfer_ctrl_if.master   bus
);
    localparam int IDXW      = $clog2(NUM_SLAVES);
    localparam int c_IDX_TOP = SEL_LSB + IDXW;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t                r_state;
    logic [IDXW-1:0]       r_idx;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [31:0]           r_paddr;
    logic [31:0]           r_pwdata;
    logic [31:0]           r_hrdata;
    logic                  r_hreadyout;
    logic                  r_err;

    logic                  w_acc;
    logic [IDXW-1:0]       w_idx;
    logic                  w_unmapped;
    logic                  w_unused;

    assign w_acc    = bus.Hsel & bus.Htrans[1] & bus.Hready_in;
    assign w_idx    = bus.Haddr[c_IDX_TOP-1:SEL_LSB];
    assign w_unused = bus.Htrans[0];

    // Address bits above the slave index must be zero for a mapped access.
    generate
        if (c_IDX_TOP < 32) begin : g_map_upper
            assign w_unmapped = |bus.Haddr[31:c_IDX_TOP];
        end else begin : g_map_full
            assign w_unmapped = 1'b0;
        end
    endgenerate

    function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [IDXW-1:0] i_idx);
        logic [NUM_SLAVES-1:0] v;
        v        = '0;
        v[i_idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwdata    <= 32'd0;
            r_hrdata    <= 32'd0;
            r_hreadyout <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                // Every state with Hreadyout high may accept the next transfer.
                S_IDLE, S_DONE, S_ERR2: begin
                    r_err     <= 1'b0;
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                    if (w_acc) begin
                        r_paddr     <= bus.Haddr;
                        r_pwrite    <= bus.Hwrite;
                        r_idx       <= w_idx;
                        r_hreadyout <= 1'b0;
                        if (w_unmapped) begin
                            r_state <= S_ERR1;
                            r_err   <= 1'b1;
                        end else if (bus.Hwrite) begin
                            r_state <= S_WDATA;
                        end else begin
                            r_state <= S_SETUP;
                            r_psel  <= f_onehot(w_idx);
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                    end
                end
                S_WDATA: begin
                    r_pwdata <= bus.Hwdata;
                    r_psel   <= f_onehot(r_idx);
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.Pready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (bus.Pslverr) begin
                            r_state <= S_ERR1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_hreadyout <= 1'b1;
                            if (!r_pwrite) begin
                                r_hrdata <= bus.Prdata;
                            end
                        end
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_psel      <= '0;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_err       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Hreadyout = r_hreadyout;
    assign bus.Hresp     = {1'b0, r_err};
    assign bus.Hrdata    = r_hrdata;
    assign bus.Psel      = r_psel;
    assign bus.Penable   = r_penable;
    assign bus.Pwrite    = r_pwrite;
    assign bus.Paddr     = r_paddr;
    assign bus.Pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_xfer_ctrl
// Brief    : Directed bench for apb_xfer_ctrl with a transaction-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_xfer_ctrl;
    localparam int NS = 4;

    logic Hclk    = 1'b0;
    logic Hresetn = 1'b0;

    apb_xfer_ctrl_if #(.NUM_SLAVES(NS)) bus ();

    apb_xfer_ctrl #(.NUM_SLAVES(NS), .SEL_LSB(12)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    always #5 Hclk = ~Hclk;

    // One bus cycle: stimulus for that cycle plus the outputs it must show.
    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rdy_in;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [3:0]  e_psel;
        logic        e_pen;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
        logic [31:0] e_hrdata;
    } rec_t;

    rec_t sc[$];
    rec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_paddr, m_pwdata, m_hrdata;
    logic        m_pwrite;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t out_rec(input logic rdy, input logic [1:0] resp,
                                     input logic [3:0] psel, input logic pen);
        rec_t r;
        r.sel = 1'b0;        r.trans = 2'b00;    r.addr = 32'd0;   r.wr = 1'b0;
        r.wdata = 32'h1111_1111;                 r.rdy_in = 1'b1;
        r.pready = 1'b1;     r.pslverr = 1'b0;   r.prdata = 32'hFFFF_0000;
        r.e_rdy = rdy;       r.e_resp = resp;    r.e_psel = psel;  r.e_pen = pen;
        r.e_paddr = m_paddr; r.e_pwrite = m_pwrite;
        r.e_pwdata = m_pwdata;                   r.e_hrdata = m_hrdata;
        return r;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) sc.push_back(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
    endtask

    task automatic add_noise(input logic sel, input logic [1:0] trans, input logic rdy_in,
                             input logic [31:0] addr, input logic wr);
        rec_t r;
        r = out_rec(1'b1, 2'b00, 4'd0, 1'b0);
        r.sel = sel; r.trans = trans; r.rdy_in = rdy_in; r.addr = addr; r.wr = wr;
        sc.push_back(r);
    endtask

    // Timeline of one transfer, counted in cycles after its address phase.
    task automatic add_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input logic slverr,
                            input bit chain);
        rec_t r;
        logic [3:0] oh;
        if (!chain || sc.size() == 0) sc.push_back(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        r = sc[sc.size()-1];
        r.sel = 1'b1; r.trans = 2'b10; r.addr = addr; r.wr = wr; r.rdy_in = 1'b1;
        sc[sc.size()-1] = r;
        m_paddr  = addr;
        m_pwrite = wr;
        if (addr >= 32'h0000_4000) begin
            sc.push_back(out_rec(1'b0, 2'b01, 4'd0, 1'b0));
            sc.push_back(out_rec(1'b1, 2'b01, 4'd0, 1'b0));
            return;
        end
        oh = 4'(1 << ((addr >> 12) % 4));
        if (wr) begin
            r = out_rec(1'b0, 2'b00, 4'd0, 1'b0);
            r.wdata = wdata;
            sc.push_back(r);
            m_pwdata = wdata;
        end
        sc.push_back(out_rec(1'b0, 2'b00, oh, 1'b0));
        for (int a = 0; a <= waits; a++) begin
            r = out_rec(1'b0, 2'b00, oh, 1'b1);
            r.pready  = (a == waits);
            r.pslverr = (a == waits) ? slverr : 1'b1;
            r.prdata  = rdata;
            sc.push_back(r);
        end
        if (slverr) begin
            sc.push_back(out_rec(1'b0, 2'b01, 4'd0, 1'b0));
            sc.push_back(out_rec(1'b1, 2'b01, 4'd0, 1'b0));
        end else begin
            if (!wr) m_hrdata = rdata;
            sc.push_back(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        end
    endtask

    task automatic drive(input rec_t r);
        bus.Hsel      = r.sel;
        bus.Htrans    = r.trans;
        bus.Haddr     = r.addr;
        bus.Hwrite    = r.wr;
        bus.Hwdata    = r.wdata;
        bus.Hready_in = r.rdy_in;
        bus.Pready    = r.pready;
        bus.Pslverr   = r.pslverr;
        bus.Prdata    = r.prdata;
    endtask

    always @(negedge Hclk) begin : cmp
        rec_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("Hreadyout", 32'(bus.Hreadyout), 32'(e.e_rdy));
            chk("Hresp",     32'(bus.Hresp),     32'(e.e_resp));
            chk("Psel",      32'(bus.Psel),      32'(e.e_psel));
            chk("Penable",   32'(bus.Penable),   32'(e.e_pen));
            chk("Paddr",     bus.Paddr,          e.e_paddr);
            chk("Pwrite",    32'(bus.Pwrite),    32'(e.e_pwrite));
            chk("Pwdata",    bus.Pwdata,         e.e_pwdata);
            chk("Hrdata",    bus.Hrdata,         e.e_hrdata);
        end
    end

    initial begin
        rec_t r;
        m_paddr = 32'd0; m_pwdata = 32'd0; m_hrdata = 32'd0; m_pwrite = 1'b0;
        drive(out_rec(1'b1, 2'b00, 4'd0, 1'b0));

        // Reset values
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        chk("rst_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        chk("rst_Hresp",     32'(bus.Hresp),     32'd0);
        chk("rst_Psel",      32'(bus.Psel),      32'd0);
        chk("rst_Penable",   32'(bus.Penable),   32'd0);
        chk("rst_Pwrite",    32'(bus.Pwrite),    32'd0);
        chk("rst_Paddr",     bus.Paddr,          32'd0);
        chk("rst_Pwdata",    bus.Pwdata,         32'd0);
        chk("rst_Hrdata",    bus.Hrdata,         32'd0);
        @(posedge Hclk); #1 Hresetn = 1'b1;

        // Zero-wait read of 0x1004, pinned with literal values
        @(posedge Hclk); #1;
        r = out_rec(1'b1, 2'b00, 4'd0, 1'b0);
        r.sel = 1'b1; r.trans = 2'b10; r.addr = 32'h0000_1004;
        drive(r);
        @(negedge Hclk);
        chk("rd0_c0_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        @(posedge Hclk); #1 drive(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        @(negedge Hclk);
        chk("rd0_c1_Psel",      32'(bus.Psel),      32'b0010);
        chk("rd0_c1_Penable",   32'(bus.Penable),   32'd0);
        chk("rd0_c1_Hreadyout", 32'(bus.Hreadyout), 32'd0);
        @(posedge Hclk); #1;
        r = out_rec(1'b1, 2'b00, 4'd0, 1'b0);
        r.prdata = 32'hA5A5_5A5A;
        drive(r);
        @(negedge Hclk);
        chk("rd0_c2_Psel",      32'(bus.Psel),      32'b0010);
        chk("rd0_c2_Penable",   32'(bus.Penable),   32'd1);
        chk("rd0_c2_Paddr",     bus.Paddr,          32'h0000_1004);
        @(posedge Hclk); #1 drive(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        @(negedge Hclk);
        chk("rd0_c3_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        chk("rd0_c3_Hrdata",    bus.Hrdata,         32'hA5A5_5A5A);
        chk("rd0_c3_Hresp",     32'(bus.Hresp),     32'd0);
        chk("rd0_c3_Psel",      32'(bus.Psel),      32'd0);

        // Model-checked scenario
        m_paddr = 32'h0000_1004; m_pwrite = 1'b0; m_pwdata = 32'd0; m_hrdata = 32'hA5A5_5A5A;
        add_noise(1'b1, 2'b01, 1'b1, 32'h0000_1000, 1'b0);
        add_noise(1'b0, 2'b10, 1'b1, 32'h0000_1000, 1'b1);
        add_noise(1'b1, 2'b10, 1'b0, 32'h0000_1000, 1'b0);
        add_noise(1'b1, 2'b00, 1'b1, 32'h0000_2000, 1'b1);
        add_xfer(32'h0000_3010, 1'b1, 32'hDEAD_BEEF, 32'h0,          3, 1'b0, 1'b0);
        add_xfer(32'h0000_0008, 1'b0, 32'h0,         32'h1234_5678, 0, 1'b0, 1'b1);
        add_idle(1);
        add_xfer(32'h0000_2004, 1'b0, 32'h0,         32'hCAFE_F00D, 1, 1'b1, 1'b0);
        add_xfer(32'h0001_0000, 1'b0, 32'h0,         32'h0,          0, 1'b0, 1'b0);
        add_xfer(32'h0000_1020, 1'b1, 32'h0F0F_0F0F, 32'h0,          0, 1'b0, 1'b1);
        add_xfer(32'h0000_2FFC, 1'b1, 32'h55AA_55AA, 32'h0,          0, 1'b1, 1'b1);
        add_xfer(32'h0000_3FFC, 1'b0, 32'h0,         32'h8765_4321, 2, 1'b0, 1'b1);
        add_xfer(32'h0000_4000, 1'b1, 32'h0,         32'h0,          0, 1'b0, 1'b1);
        add_idle(2);

        for (int i = 0; i < sc.size(); i++) begin
            @(posedge Hclk); #1;
            drive(sc[i]);
            exp_q.push_back(sc[i]);
        end
        @(posedge Hclk); #1 drive(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        for (int i = 0; i < 3 && exp_q.size() != 0; i++) @(negedge Hclk);
        chk("scenario_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of ACCESS
        @(posedge Hclk); #1;
        r = out_rec(1'b1, 2'b00, 4'd0, 1'b0);
        r.sel = 1'b1; r.trans = 2'b10; r.addr = 32'h0000_2000; r.pready = 1'b0;
        drive(r);
        @(posedge Hclk); #1;
        r = out_rec(1'b1, 2'b00, 4'd0, 1'b0);
        r.pready = 1'b0;
        drive(r);
        @(posedge Hclk); #1;
        chk("arst_pre_Penable", 32'(bus.Penable), 32'd1);
        chk("arst_pre_Psel",    32'(bus.Psel),    32'b0100);
        #1 Hresetn = 1'b0;
        #1;
        chk("arst_Psel",      32'(bus.Psel),      32'd0);
        chk("arst_Penable",   32'(bus.Penable),   32'd0);
        chk("arst_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        chk("arst_Hresp",     32'(bus.Hresp),     32'd0);
        chk("arst_Paddr",     bus.Paddr,          32'd0);
        repeat (2) @(posedge Hclk);
        #1 Hresetn = 1'b1;
        drive(out_rec(1'b1, 2'b00, 4'd0, 1'b0));
        @(negedge Hclk);
        chk("post_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        chk("post_Psel",      32'(bus.Psel),      32'd0);
        @(posedge Hclk);
        @(negedge Hclk);
        chk("post2_Hreadyout", 32'(bus.Hreadyout), 32'd1);
        chk("post2_Penable",   32'(bus.Penable),   32'd0);
        chk("post2_Hrdata",    bus.Hrdata,         32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
